// File: rtl/seg7_display_scanner.sv
// Multiplexes a 4*DIGITS-bit hex value onto a common-anode 7-segment display, one digit per scan tick.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank digits above the most-significant nonzero nibble.
module seg7_display_scanner #(
   parameter int DIGITS = 8
) (
   input  logic                clk_in,
   input  logic                rst,
   input  logic                tick_in,
   input  logic [4*DIGITS-1:0] data_in,
   input  logic [DIGITS-1:0]   dp_in,
   input  logic                blank_in,
   output logic [DIGITS-1:0]   anode_n,
   output logic [6:0]          seg_n,
   output logic                dp_n,
   output logic                frame_start
);
   localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

   logic                s1_reg, s2_reg, s3_reg;
   logic                rise, wrap;
   logic [CW-1:0]       counter_reg;
   logic                scan_run_reg;
   logic [4*DIGITS-1:0] shadow_data_reg;
   logic [DIGITS-1:0]   shadow_dp_reg;
   logic [3:0]          nibble [DIGITS];
   logic [DIGITS-1:0]   digit_sel;
   logic [DIGITS-1:0]   digit_lit;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      case (h)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h10;
         4'hA: return 7'h08;
         4'hB: return 7'h03;
         4'hC: return 7'h46;
         4'hD: return 7'h21;
         4'hE: return 7'h06;
         4'hF: return 7'h0E;
      endcase
   endfunction

   // tick_in is a divided clock used purely as data: synchronise, then detect its rising edge
   assign rise = s2_reg & ~s3_reg;
   assign wrap = rise && (counter_reg == LAST_DIGIT);

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign nibble[gi]    = shadow_data_reg[4*gi +: 4];
         assign digit_sel[gi] = (counter_reg == CW'(gi));
      end
   endgenerate

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   // A digit stays lit if it is digit 0, has its point requested, or any nibble at or above it is nonzero
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lzb
         assign digit_lit[gi] = (gi == 0) || shadow_dp_reg[gi] || (|shadow_data_reg[4*DIGITS-1:4*gi]);
      end
   endgenerate
`else
   assign digit_lit = '1;
`endif

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         s1_reg          <= 1'b0;
         s2_reg          <= 1'b0;
         s3_reg          <= 1'b0;
         counter_reg     <= '0;
         scan_run_reg    <= 1'b0;
         shadow_data_reg <= '0;
         shadow_dp_reg   <= '0;
      end else begin
         s1_reg <= tick_in;
         s2_reg <= s1_reg;
         s3_reg <= s2_reg;
         if (rise) begin
            counter_reg  <= wrap ? '0 : counter_reg + CW'(1);
            scan_run_reg <= 1'b1;
         end
         // Frame snapshot: whatever is on the inputs at the wrap is what the whole next frame shows
         if (wrap) begin
            shadow_data_reg <= data_in;
            shadow_dp_reg   <= dp_in;
         end
      end
   end

   // Display stays dark until the first scan tick so a freshly reset board shows nothing
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         anode_n     <= '1;
         seg_n       <= 7'h7F;
         dp_n        <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         frame_start <= wrap;
         seg_n       <= scan_run_reg ? hex_to_seg(nibble[counter_reg]) : 7'h7F;
         if (scan_run_reg && !blank_in && digit_lit[counter_reg]) begin
            anode_n <= ~digit_sel;
            dp_n    <= ~shadow_dp_reg[counter_reg];
         end else begin
            anode_n <= '1;
            dp_n    <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_seg7_display_scanner.sv
// Self-checking bench for seg7_display_scanner: vector table fed through a scoreboard queue plus corner sequences.
module tb_seg7_display_scanner;
   localparam int DIGITS = 8;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic        clk_in = 1'b0;
   logic        rst, tick_in, blank_in;
   logic [31:0] data_in;
   logic [7:0]  dp_in;
   logic [7:0]  anode_n;
   logic [6:0]  seg_n;
   logic        dp_n, frame_start;

   int n_vec  = 0;
   int n_miss = 0;
   int tick_no = 1;
   int m_cnt = 0;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  dp;
      logic        blank;
      logic [7:0]  anode;
      logic [6:0]  seg;
      logic        dpn;
      logic        frame;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   logic [7:0] last_anode = 8'hFF;
   logic       last_blank = 1'b0;

   seg7_display_scanner #(.DIGITS(DIGITS)) dut (
      .clk_in     (clk_in),
      .rst        (rst),
      .tick_in    (tick_in),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .blank_in   (blank_in),
      .anode_n    (anode_n),
      .seg_n      (seg_n),
      .dp_n       (dp_n),
      .frame_start(frame_start)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] d, input logic [7:0] p, input logic b,
                               input logic [7:0] a, input logic [6:0] s, input logic dn, input logic f);
      vec_t v;
      v.data = d; v.dp = p; v.blank = b; v.anode = a; v.seg = s; v.dpn = dn; v.frame = f;
      return v;
   endfunction

   function automatic logic [7:0] lz(input logic [7:0] a);
      return LZB ? 8'hFF : a;
   endfunction

   task automatic check_reset_state(input string tag);
      chk({tag, "_anode"}, anode_n, 8'hFF);
      chk({tag, "_seg"}, seg_n, 7'h7F);
      chk({tag, "_dp"}, dp_n, 1'b1);
      chk({tag, "_frame"}, frame_start, 1'b0);
   endtask

   // Tick rises before edge E; outputs must hold through E+2 and take the new digit after E+3
   task automatic apply(input vec_t v);
      vec_t e;
      @(negedge clk_in);
      data_in = v.data; dp_in = v.dp; blank_in = v.blank; tick_in = 1'b1;
      sb.push_back(v);
      @(posedge clk_in);
      @(posedge clk_in); #1;
      if (!v.blank && !last_blank) chk($sformatf("t%0d_hold_e1", tick_no), anode_n, last_anode);
      @(posedge clk_in); #1;
      if (!v.blank && !last_blank) chk($sformatf("t%0d_hold_e2", tick_no), anode_n, last_anode);
      chk($sformatf("t%0d_frame_e2", tick_no), frame_start, v.frame);
      @(posedge clk_in); #1;
      e = sb.pop_front();
      chk($sformatf("t%0d_anode", tick_no), anode_n, e.anode);
      if (!e.blank) chk($sformatf("t%0d_seg", tick_no), seg_n, e.seg);
      chk($sformatf("t%0d_dp", tick_no), dp_n, e.dpn);
      chk($sformatf("t%0d_frame_e3", tick_no), frame_start, 1'b0);
      last_anode = e.anode;
      last_blank = e.blank;
      @(negedge clk_in);
      tick_in = 1'b0;
      repeat (3) @(posedge clk_in);
      tick_no++;
   endtask

   task automatic tick_raw(output logic [7:0] an, output logic [6:0] sg);
      @(negedge clk_in);
      tick_in = 1'b1;
      repeat (4) @(posedge clk_in);
      #1;
      an = anode_n;
      sg = seg_n;
      @(negedge clk_in);
      tick_in = 1'b0;
      repeat (3) @(posedge clk_in);
   endtask

   // Loads a frame at the next wrap, then scans one full frame recording lit digits
   task automatic scan_frame(input logic [31:0] d, input logic [7:0] p,
                             output logic [7:0] lit, output logic seg_ok);
      logic [7:0] an;
      logic [6:0] sg;
      data_in = d;
      dp_in   = p;
      lit     = 8'h00;
      seg_ok  = 1'b1;
      for (int k = 0; k < DIGITS && m_cnt != DIGITS - 1; k++) begin
         tick_raw(an, sg);
         m_cnt++;
      end
      for (int i = 0; i < DIGITS; i++) begin
         tick_raw(an, sg);
         m_cnt = (m_cnt + 1) % DIGITS;
         lit |= ~an;
         if (an != 8'hFF && sg != 7'h40) seg_ok = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] d0, df;
      logic [7:0]  prev, lit;
      logic        seg_ok;
      int          changes;

      d0 = 32'h0123_4567;
      df = 32'hFFFF_FFFF;
      // Scan from reset: digits 1..7 show the zero shadow, then the wrap loads d0
      tbl.push_back(mk(d0, 8'h01, 0, lz(8'hFD), 7'h40, 1, 0));
      tbl.push_back(mk(d0, 8'h01, 0, lz(8'hFB), 7'h40, 1, 0));
      tbl.push_back(mk(d0, 8'h01, 0, lz(8'hF7), 7'h40, 1, 0));
      tbl.push_back(mk(d0, 8'h01, 0, lz(8'hEF), 7'h40, 1, 0));
      tbl.push_back(mk(d0, 8'h01, 0, lz(8'hDF), 7'h40, 1, 0));
      tbl.push_back(mk(d0, 8'h01, 0, lz(8'hBF), 7'h40, 1, 0));
      tbl.push_back(mk(d0, 8'h01, 0, lz(8'h7F), 7'h40, 1, 0));
      tbl.push_back(mk(d0, 8'h01, 0, 8'hFE, 7'h78, 0, 1));
      tbl.push_back(mk(d0, 8'h01, 0, 8'hFD, 7'h02, 1, 0));
      tbl.push_back(mk(d0, 8'h01, 0, 8'hFB, 7'h12, 1, 0));
      tbl.push_back(mk(d0, 8'h01, 0, 8'hF7, 7'h19, 1, 0));
      tbl.push_back(mk(d0, 8'h01, 0, 8'hEF, 7'h30, 1, 0));
      tbl.push_back(mk(d0, 8'h01, 0, 8'hDF, 7'h24, 1, 0));
      tbl.push_back(mk(d0, 8'h01, 0, 8'hBF, 7'h79, 1, 0));
      tbl.push_back(mk(d0, 8'h01, 0, lz(8'h7F), 7'h40, 1, 0));
      tbl.push_back(mk(d0, 8'h01, 0, 8'hFE, 7'h78, 0, 1));
      tbl.push_back(mk(d0, 8'h01, 0, 8'hFD, 7'h02, 1, 0));
      tbl.push_back(mk(d0, 8'h01, 0, 8'hFB, 7'h12, 1, 0));
      tbl.push_back(mk(d0, 8'h01, 0, 8'hF7, 7'h19, 1, 0));
      // Data changes at digit 3: digits 4..7 keep old nibbles until the wrap
      tbl.push_back(mk(df, 8'h01, 0, 8'hEF, 7'h30, 1, 0));
      tbl.push_back(mk(df, 8'h01, 0, 8'hDF, 7'h24, 1, 0));
      tbl.push_back(mk(df, 8'h01, 0, 8'hBF, 7'h79, 1, 0));
      tbl.push_back(mk(df, 8'h01, 0, lz(8'h7F), 7'h40, 1, 0));
      tbl.push_back(mk(df, 8'h01, 0, 8'hFE, 7'h0E, 0, 1));
      tbl.push_back(mk(df, 8'h01, 0, 8'hFD, 7'h0E, 1, 0));
      // Blank together with a tick: dark, but the counter still advances
      tbl.push_back(mk(df, 8'h01, 1, 8'hFF, 7'h0E, 1, 0));
      tbl.push_back(mk(df, 8'h01, 0, 8'hF7, 7'h0E, 1, 0));
      tbl.push_back(mk(df, 8'h01, 0, 8'hEF, 7'h0E, 1, 0));
      tbl.push_back(mk(df, 8'h01, 0, 8'hDF, 7'h0E, 1, 0));
      tbl.push_back(mk(df, 8'h01, 0, 8'hBF, 7'h0E, 1, 0));
      tbl.push_back(mk(df, 8'h01, 0, 8'h7F, 7'h0E, 1, 0));

      rst = 1'b1; tick_in = 1'b0; blank_in = 1'b0; data_in = '0; dp_in = '0;
      repeat (3) @(posedge clk_in);
      #1;
      check_reset_state("rst_held");
      @(negedge clk_in);
      rst = 1'b0;
      repeat (10) @(posedge clk_in);
      #1;
      check_reset_state("rst_idle");

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

      // Asynchronous reset mid-scan takes effect before any clock edge
      @(negedge clk_in);
      #2;
      rst = 1'b1;
      #1;
      check_reset_state("rst_async");
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      rst = 1'b0;
      repeat (10) @(posedge clk_in);
      #1;
      check_reset_state("rst_release");
      m_cnt = 0;

      // Tick held high for 50 cycles gives a single advance
      @(negedge clk_in);
      tick_in = 1'b1;
      prev = anode_n;
      changes = 0;
      repeat (50) begin
         @(posedge clk_in); #1;
         if (anode_n !== prev) changes++;
         prev = anode_n;
      end
      @(negedge clk_in);
      tick_in = 1'b0;
      repeat (5) begin
         @(posedge clk_in); #1;
         if (anode_n !== prev) changes++;
         prev = anode_n;
      end
      chk("hold_changes", changes, LZB ? 0 : 1);
      chk("hold_anode", anode_n, lz(8'hFD));
      m_cnt = 1;

      // Blank pulse without ticks: dark on the next edge, back one edge after release
      @(negedge clk_in);
      blank_in = 1'b1;
      @(posedge clk_in); #1;
      chk("blank_on", anode_n, 8'hFF);
      chk("blank_on_dp", dp_n, 1'b1);
      repeat (9) @(posedge clk_in);
      #1;
      chk("blank_held", anode_n, 8'hFF);
      @(negedge clk_in);
      blank_in = 1'b0;
      @(posedge clk_in); #1;
      chk("blank_release", anode_n, lz(8'hFD));

      scan_frame(32'h0000_00A5, 8'h00, lit, seg_ok);
      chk("lzb_a5_lit", lit, LZB ? 8'h03 : 8'hFF);
      scan_frame(32'h0000_0000, 8'h00, lit, seg_ok);
      chk("lzb_zero_lit", lit, LZB ? 8'h01 : 8'hFF);
      chk("lzb_zero_seg", seg_ok, 1'b1);
      scan_frame(32'h0000_0000, 8'h10, lit, seg_ok);
      chk("lzb_dp4_lit", lit, LZB ? 8'h11 : 8'hFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
